approx_mult_ctrl: RTL and testbench

Sequencing FSM for the approximate-multiplier datapath. It walks the 16-word input RAM as 8 operand pairs. For each pair it drives the load, leading-one normalisation, truncated multiply, denormalising shift and output-RAM write, then signals completion with a `start`/`done` handshake. It sits beside the datapath in the top level and owns every datapath control strobe.

---
 rtl/approx_mult_ctrl.sv | 112 +++++++++++
 tb/tb_approx_mult_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/approx_mult_ctrl.sv
// Sequencing FSM for the approximate-multiplier datapath: walks 8 operand pairs
// through load, normalise, multiply, denormalise and write. Optional NORM watchdog: APPROX_MULT_CTRL_NORM_WDT_EN.
module approx_mult_ctrl #(
    parameter int WDT_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic co_cntr_ld,
    input  logic end_shift1,
    input  logic end_shift2,
    input  logic co_cnt_sh,
    output logic cntr_ld_init,
    output logic cntr_ld_en,
    output logic cntr_sh1_init,
    output logic cntr_sh2_init,
    output logic en_sh_16bit,
    output logic sh_result_ld,
    output logic sh_result_shift,
    output logic cntr_sh_ld,
    output logic cntr_sh_en,
    output logic wr_out_ram,
    output logic busy,
    output logic done,
    output logic err
);

    typedef enum logic [3:0] {
        IDLE, INIT, LOAD_A, LOAD_B, NORM, MUL, DENORM, WRITE, FIN
    } state_t;

    if (WDT_CYCLES < 1 || WDT_CYCLES > 15) begin : g_bad_wdt
        $error("WDT_CYCLES must be in 1..15");
    end

    state_t state;
    logic   last;
    logic   norm_clear;

    assign norm_clear = !end_shift1 && !end_shift2;

`ifdef APPROX_MULT_CTRL_NORM_WDT_EN
    localparam logic [3:0] WDT_LAST = 4'(WDT_CYCLES - 1);
    logic [3:0] wdt_cnt;
    logic       err_q;
    logic       wdt_fire;

    // wdt_cnt holds the number of NORM cycles already spent, so the limit
    // trips on the WDT_CYCLES-th cycle of NORM.
    assign wdt_fire = (wdt_cnt == WDT_LAST) && !norm_clear;
    assign err      = err_q;
`else
    logic wdt_fire;
    assign wdt_fire = 1'b0;
    assign err      = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            last    <= 1'b0;
`ifdef APPROX_MULT_CTRL_NORM_WDT_EN
            wdt_cnt <= 4'd0;
            err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE:   if (start) state <= INIT;
                INIT: begin
                    last  <= 1'b0;
                    state <= LOAD_A;
                end
                LOAD_A: state <= LOAD_B;
                LOAD_B: begin
                    last    <= co_cntr_ld;
`ifdef APPROX_MULT_CTRL_NORM_WDT_EN
                    wdt_cnt <= 4'd0;
`endif
                    state   <= NORM;
                end
                NORM: begin
`ifdef APPROX_MULT_CTRL_NORM_WDT_EN
                    wdt_cnt <= wdt_cnt + 4'd1;
                    if (wdt_fire) err_q <= 1'b1;
`endif
                    if (norm_clear || wdt_fire) state <= MUL;
                end
                MUL:    state <= DENORM;
                DENORM: if (co_cnt_sh) state <= WRITE;
                WRITE:  state <= last ? FIN : LOAD_A;
                FIN:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes decode the registered state; DENORM also gates on the carry so
    // the exit cycle neither shifts nor counts.
    assign cntr_ld_init    = (state == INIT);
    assign cntr_ld_en      = (state == LOAD_A) || (state == LOAD_B);
    assign cntr_sh1_init   = (state == LOAD_A);
    assign cntr_sh2_init   = (state == LOAD_A);
    assign en_sh_16bit     = (state == LOAD_A) || (state == LOAD_B);
    assign sh_result_ld    = (state == MUL);
    assign cntr_sh_ld      = (state == MUL);
    assign sh_result_shift = (state == DENORM) && !co_cnt_sh;
    assign cntr_sh_en      = (state == DENORM) && !co_cnt_sh;
    assign wr_out_ram      = (state == WRITE);
    assign busy            = (state != IDLE);
    assign done            = (state == FIN);

endmodule

// File: tb/tb_approx_mult_ctrl.sv
// Self-checking bench for approx_mult_ctrl: a per-cycle expected trace is
// planned from per-pair NORM/DENORM lengths and replayed against the DUT.
module tb_approx_mult_ctrl;

    localparam int WDT = 8;
`ifdef APPROX_MULT_CTRL_NORM_WDT_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif

    // Bit order: ld_init ld_en sh1_init sh2_init en16 res_ld res_shift sh_ld sh_en wr busy done err
    localparam logic [12:0] M_IDLE  = 13'b0_0000_0000_0000;
    localparam logic [12:0] M_INIT  = 13'b1_0000_0000_0100;
    localparam logic [12:0] M_LOADA = 13'b0_1111_0000_0100;
    localparam logic [12:0] M_LOADB = 13'b0_1001_0000_0100;
    localparam logic [12:0] M_NORM  = 13'b0_0000_0000_0100;
    localparam logic [12:0] M_MUL   = 13'b0_0000_1010_0100;
    localparam logic [12:0] M_DSH   = 13'b0_0000_0101_0100;
    localparam logic [12:0] M_DEX   = 13'b0_0000_0000_0100;
    localparam logic [12:0] M_WR    = 13'b0_0000_0000_1100;
    localparam logic [12:0] M_FIN   = 13'b0_0000_0000_0110;

    logic clk = 1'b0;
    logic rst, start, co_cntr_ld, end_shift1, end_shift2, co_cnt_sh;
    logic cntr_ld_init, cntr_ld_en, cntr_sh1_init, cntr_sh2_init, en_sh_16bit;
    logic sh_result_ld, sh_result_shift, cntr_sh_ld, cntr_sh_en, wr_out_ram;
    logic busy, done, err;

    approx_mult_ctrl #(.WDT_CYCLES(WDT)) dut (
        .clk(clk), .rst(rst), .start(start), .co_cntr_ld(co_cntr_ld),
        .end_shift1(end_shift1), .end_shift2(end_shift2), .co_cnt_sh(co_cnt_sh),
        .cntr_ld_init(cntr_ld_init), .cntr_ld_en(cntr_ld_en),
        .cntr_sh1_init(cntr_sh1_init), .cntr_sh2_init(cntr_sh2_init),
        .en_sh_16bit(en_sh_16bit), .sh_result_ld(sh_result_ld),
        .sh_result_shift(sh_result_shift), .cntr_sh_ld(cntr_sh_ld),
        .cntr_sh_en(cntr_sh_en), .wr_out_ram(wr_out_ram),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    wire [12:0] obs = {cntr_ld_init, cntr_ld_en, cntr_sh1_init, cntr_sh2_init, en_sh_16bit,
                       sh_result_ld, sh_result_shift, cntr_sh_ld, cntr_sh_en, wr_out_ram,
                       busy, done, err};

    typedef struct {
        logic [12:0] exp;
        logic        st, cl, e1, e2, cs;
    } cyc_t;

    cyc_t        plan_q[$];
    int          nn[8];
    int          dd[8];
    logic [1:0]  sel[8];
    logic        err_m;
    int          n_checks = 0;
    int          n_fail = 0;
    int          den_idx;

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_checks++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic [12:0] m, input logic st, input logic cl,
                        input logic e1, input logic e2, input logic cs);
        cyc_t c;
        c.exp = m | {12'b0, err_m};
        c.st = st; c.cl = cl; c.e1 = e1; c.e2 = e2; c.cs = cs;
        plan_q.push_back(c);
    endtask

    // Expected trace of one full run, starting with the IDLE cycle that samples start.
    task automatic build_run(output int didx);
        int eff;
        logic hi;
        plan_q.delete();
        didx = -1;
        push(M_IDLE, 1'b1, rb(), rb(), rb(), rb());
        push(M_INIT, rb(), rb(), rb(), rb(), rb());
        for (int p = 0; p < 8; p++) begin
            push(M_LOADA, rb(), rb(), rb(), rb(), rb());
            push(M_LOADB, rb(), (p == 7), rb(), rb(), rb());
            eff = (WDT_ON && nn[p] > WDT) ? WDT : nn[p];
            for (int j = 0; j < eff; j++) begin
                hi = (j < nn[p] - 1);
                push(M_NORM, rb(), rb(), hi && sel[p][0], hi && sel[p][1], rb());
            end
            if (eff < nn[p]) err_m = 1'b1;
            push(M_MUL, rb(), rb(), rb(), rb(), rb());
            for (int j = 0; j < dd[p]; j++) begin
                if (j == dd[p] - 1) begin
                    push(M_DEX, rb(), rb(), rb(), rb(), 1'b1);
                end else begin
                    if (p == 2 && j == 0) didx = plan_q.size();
                    push(M_DSH, rb(), rb(), rb(), rb(), 1'b0);
                end
            end
            push(M_WR, rb(), rb(), rb(), rb(), rb());
        end
        push(M_FIN, rb(), rb(), rb(), rb(), rb());
    endtask

    task automatic exec_plan(input int stop_at);
        int wr = 0, en = 0, dn = 0, li = 0;
        for (int i = 0; i < plan_q.size(); i++) begin
            start = plan_q[i].st; co_cntr_ld = plan_q[i].cl;
            end_shift1 = plan_q[i].e1; end_shift2 = plan_q[i].e2; co_cnt_sh = plan_q[i].cs;
            #1;
            check($sformatf("cycle%0d", i), obs, plan_q[i].exp);
            wr += int'(wr_out_ram); en += int'(en_sh_16bit);
            dn += int'(done); li += int'(cntr_ld_init);
            if (i == stop_at) return;
            @(posedge clk); #1;
        end
        check("wr_count", wr, 8);
        check("en16_count", en, 16);
        check("done_count", dn, 1);
        check("ld_init_count", li, 1);
    endtask

    task automatic rand_pairs();
        for (int p = 0; p < 8; p++) begin
            nn[p]  = $urandom_range(1, 6);
            dd[p]  = $urandom_range(1, 4);
            sel[p] = 2'($urandom_range(1, 3));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; co_cntr_ld = 1'b0;
        end_shift1 = 1'b0; end_shift2 = 1'b0; co_cnt_sh = 1'b0;
        err_m = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", obs, 13'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_after_reset", obs, 13'd0);

        // Nominal: shifts drop one cycle into NORM, carry three cycles after MUL.
        for (int p = 0; p < 8; p++) begin
            nn[p] = 2; dd[p] = 3; sel[p] = 2'b11;
        end
        build_run(den_idx);
        exec_plan(-1);

        // Random pairs plus zero denorm, asymmetric NORM and a stuck operand.
        rand_pairs();
        dd[0] = 1;
        nn[1] = 6; sel[1] = 2'b10;
        nn[3] = 12; sel[3] = 2'b01;
        build_run(den_idx);
        exec_plan(-1);

        // Asynchronous reset in the middle of pair 2's DENORM.
        rand_pairs();
        dd[2] = 3;
        build_run(den_idx);
        exec_plan(den_idx);
        rst = 1'b1;
        #1;
        check("async_reset_outputs", obs, 13'd0);
        err_m = 1'b0;
        @(posedge clk); #1;
        check("held_reset_outputs", obs, 13'd0);
        rst = 1'b0;

        // Fresh run after reset must restart at pair 0.
        rand_pairs();
        build_run(den_idx);
        exec_plan(-1);

        rst = 1'b1;
        #1;
        check("final_reset", obs, 13'd0);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
